// File: rtl/tdm_demux.sv
// tdm_demux
//   Receive end of the mux-based TDM link: a 1-to-CH registered demultiplexer.
//   Each enabled sample on din_i is steered into channel slot s_o. The slot counter
//   is aligned to the frame-start pulse sync_i, so one serial stream becomes CH
//   parallel channels again.
//
// Ports
//   clk_i         rising-edge clock
//   rst_i         asynchronous, active-high reset
//   en_i          sample enable; low = stall, nothing advances or updates
//   sync_i        frame start (qualified by en_i); marks din_i as the slot-0 sample
//   din_i         incoming W-bit TDM sample
//   y_o           channel registers; channel k = y_o[k*W +: W]
//   vld_o         one-cycle strobe, bit k set the cycle after channel k is written
//   s_o           slot the next enabled sample is written to
//   frame_done_o  one-cycle pulse the cycle after slot CH-1 is written
//   err_o         one-cycle pulse when a sync arrives at a slot other than 0
//   locked_o      high while the receiver is aligned (RUN)

module tdm_demux #(
  parameter int CH = 4,
  parameter int W  = 1,
  localparam int SW = $clog2(CH)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            en_i,
  input  logic            sync_i,
  input  logic [W-1:0]    din_i,
  output logic [CH*W-1:0] y_o,
  output logic [CH-1:0]   vld_o,
  output logic [SW-1:0]   s_o,
  output logic            frame_done_o,
  output logic            err_o,
  output logic            locked_o
);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  localparam logic [SW-1:0] LastSlot = SW'(CH - 1);
  localparam logic [SW-1:0] Slot1    = SW'(1);

  state_t          state_q, state_d;
  logic [SW-1:0]   s_q, s_d;
  logic [CH*W-1:0] y_q, y_d;
  logic [CH-1:0]   vld_q, vld_d;
  logic            frameDone_q, frameDone_d;
  logic            err_q, err_d;

  // Next-state logic. Every output is a register, so all of the steering work
  // happens here and the strobes default to zero: they only fire on an enabled
  // write, which also keeps them low during stalls. A sync always forces the
  // sample into channel 0 and restarts the count at slot 1, whether the frame
  // was aligned or not; only a misaligned one raises err, and because that path
  // never writes the last slot it can never produce a frame_done for the
  // truncated frame.
  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    y_d         = y_q;
    vld_d       = '0;
    frameDone_d = 1'b0;
    err_d       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (en_i && sync_i) begin
          y_d[0 +: W] = din_i;
          vld_d[0]    = 1'b1;
          s_d         = Slot1;
          state_d     = RUN;
        end
      end

      RUN: begin
        if (en_i) begin
          if (sync_i) begin
            y_d[0 +: W] = din_i;
            vld_d[0]    = 1'b1;
            s_d         = Slot1;
            err_d       = (s_q != '0);
          end else begin
            y_d[s_q*W +: W] = din_i;
            vld_d[s_q]      = 1'b1;
            frameDone_d     = (s_q == LastSlot);
            s_d             = (s_q == LastSlot) ? '0 : s_q + Slot1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers. Reset clears everything immediately so a
  // mid-frame reset drops lock and the channel contents at once.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      s_q         <= '0;
      y_q         <= '0;
      vld_q       <= '0;
      frameDone_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      y_q         <= y_d;
      vld_q       <= vld_d;
      frameDone_q <= frameDone_d;
      err_q       <= err_d;
    end
  end

  assign y_o          = y_q;
  assign vld_o        = vld_q;
  assign s_o          = s_q;
  assign frame_done_o = frameDone_q;
  assign err_o        = err_q;
  assign locked_o     = (state_q == RUN);

endmodule

// File: tb/tb_tdm_demux.sv
// tb_tdm_demux
//   Directed bench for tdm_demux. One instance uses the default CH=4, W=1 build;
//   a second instance with CH=2 covers the two-slot frame and all a/b combinations.

module tb_tdm_demux;

  logic       clk;
  logic       rst;

  logic       en4, sync4, din4;
  logic [3:0] y4, vld4;
  logic [1:0] s4;
  logic       fd4, err4, lock4;

  logic       en2, sync2, din2;
  logic [1:0] y2, vld2;
  logic [0:0] s2;
  logic       fd2, err2, lock2;

  int vectors;
  int miscompares;

  tdm_demux #(.CH(4), .W(1)) u4 (
    .clk_i        (clk),
    .rst_i        (rst),
    .en_i         (en4),
    .sync_i       (sync4),
    .din_i        (din4),
    .y_o          (y4),
    .vld_o        (vld4),
    .s_o          (s4),
    .frame_done_o (fd4),
    .err_o        (err4),
    .locked_o     (lock4)
  );

  tdm_demux #(.CH(2), .W(1)) u2 (
    .clk_i        (clk),
    .rst_i        (rst),
    .en_i         (en2),
    .sync_i       (sync2),
    .din_i        (din2),
    .y_o          (y2),
    .vld_o        (vld2),
    .s_o          (s2),
    .frame_done_o (fd2),
    .err_o        (err2),
    .locked_o     (lock2)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts the vector and reports any miscompare.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks every output of the CH=4 instance against hand-computed values.
  task automatic check4(input string tag, input logic [3:0] y, input logic [3:0] vld,
                        input logic [1:0] s, input logic fd, input logic err,
                        input logic lock);
    checkOutput({tag, ".y"},      32'(y4),    32'(y));
    checkOutput({tag, ".vld"},    32'(vld4),  32'(vld));
    checkOutput({tag, ".s"},      32'(s4),    32'(s));
    checkOutput({tag, ".fdone"},  32'(fd4),   32'(fd));
    checkOutput({tag, ".err"},    32'(err4),  32'(err));
    checkOutput({tag, ".locked"}, 32'(lock4), 32'(lock));
  endtask

  // One sample into the CH=4 instance; outputs are settled 1 time unit after the edge.
  task automatic applyStimulus(input logic en, input logic sync, input logic din);
    en4   = en;
    sync4 = sync;
    din4  = din;
    @(posedge clk);
    #1;
  endtask

  // One sample into the CH=2 instance.
  task automatic applyStimulus2(input logic sync, input logic din);
    en2   = 1'b1;
    sync2 = sync;
    din2  = din;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst   = 1'b1;
    en4   = 1'b0; sync4 = 1'b0; din4 = 1'b0;
    en2   = 1'b0; sync2 = 1'b0; din2 = 1'b0;

    // Reset state
    #12;
    check4("reset", 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    // Samples without sync are ignored in IDLE
    applyStimulus(1'b1, 1'b0, 1'b1);
    check4("idle0", 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    check4("idle1", 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);

    // Frame 1: sync + din 1,0,1,1
    applyStimulus(1'b1, 1'b1, 1'b1);
    check4("f1s0", 4'b0001, 4'b0001, 2'd1, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    check4("f1s1", 4'b0001, 4'b0010, 2'd2, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    check4("f1s2", 4'b0101, 4'b0100, 2'd3, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    check4("f1s3", 4'b1101, 4'b1000, 2'd0, 1'b1, 1'b0, 1'b1);

    // Frame 2: wrap without sync, din 0,1,0,0
    applyStimulus(1'b1, 1'b0, 1'b0);
    check4("f2s0", 4'b1100, 4'b0001, 2'd1, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    check4("f2s1", 4'b1110, 4'b0010, 2'd2, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    check4("f2s2", 4'b1010, 4'b0100, 2'd3, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    check4("f2s3", 4'b0010, 4'b1000, 2'd0, 1'b1, 1'b0, 1'b1);

    // Stall at s=2 for three cycles (one with sync high, which must be ignored)
    applyStimulus(1'b1, 1'b0, 1'b1);
    check4("f3s0", 4'b0011, 4'b0001, 2'd1, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    check4("f3s1", 4'b0011, 4'b0010, 2'd2, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    check4("stall0", 4'b0011, 4'b0000, 2'd2, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1);
    check4("stall1", 4'b0011, 4'b0000, 2'd2, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    check4("stall2", 4'b0011, 4'b0000, 2'd2, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    check4("f3s2", 4'b0111, 4'b0100, 2'd3, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    check4("f3s3", 4'b0111, 4'b1000, 2'd0, 1'b1, 1'b0, 1'b1);

    // Misaligned sync at s=2
    applyStimulus(1'b1, 1'b0, 1'b0);
    check4("f4s0", 4'b0110, 4'b0001, 2'd1, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    check4("f4s1", 4'b0100, 4'b0010, 2'd2, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1);
    check4("resync2", 4'b0101, 4'b0001, 2'd1, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    check4("f5s1", 4'b0111, 4'b0010, 2'd2, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    check4("f5s2", 4'b0111, 4'b0100, 2'd3, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    check4("f5s3", 4'b0111, 4'b1000, 2'd0, 1'b1, 1'b0, 1'b1);

    // Sync exactly at the wrap is consistent
    applyStimulus(1'b1, 1'b1, 1'b0);
    check4("syncwrap", 4'b0110, 4'b0001, 2'd1, 1'b0, 1'b0, 1'b1);

    // Misaligned sync at the last slot: err but no frame_done
    applyStimulus(1'b1, 1'b0, 1'b1);
    check4("f6s1", 4'b0110, 4'b0010, 2'd2, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    check4("f6s2", 4'b0010, 4'b0100, 2'd3, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1);
    check4("resync3", 4'b0011, 4'b0001, 2'd1, 1'b0, 1'b1, 1'b1);

    // Asynchronous reset mid-frame, then non-sync samples are ignored
    #2;
    rst = 1'b1;
    #1;
    check4("asyncrst", 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b1);
    check4("postrst0", 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    check4("postrst1", 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
    en4 = 1'b0;

    // CH=2: every a/b combination as a two-slot frame
    for (int ab = 0; ab < 4; ab++) begin
      logic a, b;
      a = ab[1];
      b = ab[0];
      applyStimulus2(1'b1, a);
      checkOutput($sformatf("ch2_%0d.vld0", ab), 32'(vld2), 32'b01);
      checkOutput($sformatf("ch2_%0d.s0", ab),   32'(s2),   32'd1);
      checkOutput($sformatf("ch2_%0d.y0", ab),   32'(y2[0]), 32'(a));
      applyStimulus2(1'b0, b);
      checkOutput($sformatf("ch2_%0d.y", ab),    32'(y2),   32'({b, a}));
      checkOutput($sformatf("ch2_%0d.vld1", ab), 32'(vld2), 32'b10);
      checkOutput($sformatf("ch2_%0d.s1", ab),   32'(s2),   32'd0);
      checkOutput($sformatf("ch2_%0d.fd", ab),   32'(fd2),  32'd1);
      checkOutput($sformatf("ch2_%0d.err", ab),  32'(err2), 32'd0);
      checkOutput($sformatf("ch2_%0d.lock", ab), 32'(lock2), 32'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
